// File: rtl/axis_pkt_fifo.sv
// axis_pkt_fifo
//   Packet-aware AXI4-Stream buffer for a source that cannot be stalled
//   (tvalid held high, tready ignored). Beats are absorbed into a show-ahead
//   FIFO and re-presented with real backpressure. On overflow, packets are
//   truncated (last forced on the final stored beat) or dropped whole, so the
//   output stream is always well-framed. Packet length is checked against
//   PACKET_BEATS and sticky status flags / counters are exposed.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   s_tdata/tvalid/tlast  input beat (s_tready is advisory only)
//   m_tdata/tvalid/tlast  output beat, m_tready is downstream backpressure
//   level                 current FIFO occupancy
//   overflow              sticky, set by any dropped beat
//   truncated             sticky, set by any forced last
//   len_err               sticky, set by a packet length mismatch
//   drop_cnt              dropped beats, saturating
//   pkt_cnt               packets written (truncated ones included), wrapping
module axis_pkt_fifo #(
   parameter int DATA_WIDTH   = 64,
   parameter int DEPTH        = 512,
   parameter int PACKET_BEATS = 524288
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [DATA_WIDTH-1:0]      s_tdata,
   input  logic                       s_tvalid,
   input  logic                       s_tlast,
   output logic                       s_tready,
   output logic [DATA_WIDTH-1:0]      m_tdata,
   output logic                       m_tvalid,
   output logic                       m_tlast,
   input  logic                       m_tready,
   output logic [$clog2(DEPTH+1)-1:0] level,
   output logic                       overflow,
   output logic                       truncated,
   output logic                       len_err,
   output logic [31:0]                drop_cnt,
   output logic [31:0]                pkt_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = $clog2(DEPTH+1);
   localparam int IW = (PACKET_BEATS > 1) ? $clog2(PACKET_BEATS) : 1;

   localparam logic [LW-1:0] LVL_FULL   = LW'(DEPTH);
   localparam logic [LW-1:0] LVL_ALMOST = LW'(DEPTH-1);
   localparam logic [AW-1:0] PTR_LAST   = AW'(DEPTH-1);
   localparam logic [IW-1:0] IDX_LAST   = IW'(PACKET_BEATS-1);

   typedef enum logic [0:0] {ST_PASS = 1'b0, ST_DISCARD = 1'b1} state_t;

   state_t              state_r, state_nxt_s;
   logic [DATA_WIDTH:0] mem_r [DEPTH];
   logic [AW-1:0]       wr_ptr_r, rd_ptr_r;
   logic [LW-1:0]       count_r;
   logic                sop_r;
   logic [IW-1:0]       idx_r;
   logic                overflow_r, truncated_r, len_err_r;
   logic [31:0]         drop_cnt_r, pkt_cnt_r;

   logic push_s, drop_s, wr_last_s, trunc_s, pop_s, len_bad_s;

   assign m_tvalid  = (count_r != {LW{1'b0}});
   assign m_tdata   = mem_r[rd_ptr_r][DATA_WIDTH-1:0];
   assign m_tlast   = mem_r[rd_ptr_r][DATA_WIDTH];
   assign s_tready  = (count_r < LVL_ALMOST);
   assign level     = count_r;
   assign overflow  = overflow_r;
   assign truncated = truncated_r;
   assign len_err   = len_err_r;
   assign drop_cnt  = drop_cnt_r;
   assign pkt_cnt   = pkt_cnt_r;

   assign pop_s = m_tvalid & m_tready;
   // Length is wrong when tlast and "index at final beat" disagree.
   assign len_bad_s = s_tvalid & (s_tlast != (idx_r == IDX_LAST));

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_PASS;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // FSM next state: any beat that cannot be stored whole, and is not the
   // end of its packet, sends the rest of the packet to DISCARD.
   always_comb begin
      state_nxt_s = state_r;
      if (s_tvalid) begin
         case (state_r)
            ST_PASS: begin
               if ((count_r >= LVL_ALMOST) && !s_tlast) begin
                  state_nxt_s = ST_DISCARD;
               end else begin
                  state_nxt_s = ST_PASS;
               end
            end
            ST_DISCARD: begin
               if (s_tlast) begin
                  state_nxt_s = ST_PASS;
               end else begin
                  state_nxt_s = ST_DISCARD;
               end
            end
            default: state_nxt_s = ST_PASS;
         endcase
      end else begin
         state_nxt_s = state_r;
      end
   end

   // FSM outputs: push/drop decision from start-of-cycle occupancy only.
   // The last free slot is reserved for a forced-last closing beat or a
   // genuine one-beat packet, so a started packet can always be terminated.
   always_comb begin
      push_s    = 1'b0;
      drop_s    = 1'b0;
      wr_last_s = s_tlast;
      trunc_s   = 1'b0;
      if (s_tvalid) begin
         case (state_r)
            ST_PASS: begin
               if (count_r < LVL_ALMOST) begin
                  push_s = 1'b1;
               end else if (count_r == LVL_ALMOST) begin
                  if (!sop_r) begin
                     push_s    = 1'b1;
                     wr_last_s = 1'b1;
                     trunc_s   = !s_tlast;
                  end else if (s_tlast) begin
                     push_s    = 1'b1;
                     wr_last_s = 1'b1;
                  end else begin
                     drop_s = 1'b1;
                  end
               end else begin
                  drop_s = 1'b1;
               end
            end
            ST_DISCARD: drop_s = 1'b1;
            default:    drop_s = 1'b1;
         endcase
      end else begin
         push_s = 1'b0;
      end
   end

   // FIFO storage; data is not reset, validity comes from count_r.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= {wr_last_s, s_tdata};
      end else begin
         mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
      end
   end

   // Pointers, occupancy, framing tracker and length index.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         count_r  <= {LW{1'b0}};
         sop_r    <= 1'b1;
         idx_r    <= {IW{1'b0}};
      end else begin
         if (push_s) begin
            wr_ptr_r <= (wr_ptr_r == PTR_LAST) ? {AW{1'b0}} : wr_ptr_r + AW'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= (rd_ptr_r == PTR_LAST) ? {AW{1'b0}} : rd_ptr_r + AW'(1);
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + LW'(1);
            2'b01:   count_r <= count_r - LW'(1);
            default: count_r <= count_r;
         endcase
         if (s_tvalid) begin
            sop_r <= s_tlast;
            idx_r <= (s_tlast || (idx_r == IDX_LAST)) ? {IW{1'b0}} : idx_r + IW'(1);
         end
      end
   end

   // Sticky status flags and counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         overflow_r  <= 1'b0;
         truncated_r <= 1'b0;
         len_err_r   <= 1'b0;
         drop_cnt_r  <= 32'd0;
         pkt_cnt_r   <= 32'd0;
      end else begin
         if (drop_s) begin
            overflow_r <= 1'b1;
            if (drop_cnt_r != 32'hFFFF_FFFF) begin
               drop_cnt_r <= drop_cnt_r + 32'd1;
            end
         end
         if (trunc_s) begin
            truncated_r <= 1'b1;
         end
         if (len_bad_s) begin
            len_err_r <= 1'b1;
         end
         if (push_s && wr_last_s) begin
            pkt_cnt_r <= pkt_cnt_r + 32'd1;
         end
      end
   end

endmodule
